// File: rtl/mipi_csi2_frame_sched_if.sv
// CSI-2 packet header port: header fields towards the lane/ECC stage
// with a valid/ready handshake.
interface mipi_csi2_frame_sched_if;
    logic        hdr_valid;
    logic        hdr_ready;
    logic [7:0]  hdr_di;
    logic [15:0] hdr_wc;
    logic        hdr_long;

    modport master (
        output hdr_valid,
        output hdr_di,
        output hdr_wc,
        output hdr_long,
        input  hdr_ready
    );

    modport slave (
        input  hdr_valid,
        input  hdr_di,
        input  hdr_wc,
        input  hdr_long,
        output hdr_ready
    );
endinterface

// File: rtl/mipi_csi2_frame_sched.sv
// CSI-2 frame packet sequencer: FS, per-line LS/long/LE, generic short
// packets in line gaps, FE; one payload grant per line.
module mipi_csi2_frame_sched #(
    parameter int LINES_W = 12,
    parameter int WC_W    = 16
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [1:0]         cfg_vc,
    input  logic [5:0]         cfg_dt,
    input  logic [LINES_W-1:0] cfg_lines,
    input  logic [WC_W-1:0]    cfg_wc,
    input  logic               cfg_lsle_en,
    input  logic               start,
    output logic               busy,
    output logic               frame_done,
    input  logic               gsp_req,
    input  logic [5:0]         gsp_dt,
    input  logic [15:0]        gsp_data,
    output logic               gsp_ack,
    mipi_csi2_frame_sched_if.master hdr,
    output logic               pl_start,
    input  logic               pl_done
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FS,
        S_LS,
        S_LP,
        S_PL,
        S_LE,
        S_GAP,
        S_GSP,
        S_FE
    } state_t;

    state_t state, state_d;

    logic [1:0]         lat_vc;
    logic [5:0]         lat_dt;
    logic [LINES_W-1:0] lat_lines;
    logic [WC_W-1:0]    lat_wc;
    logic               lat_lsle;
    logic [15:0]        frame_num;
    logic [LINES_W-1:0] line;
    logic [5:0]         gsp_dt_q;
    logic [15:0]        gsp_data_q;

    logic        hv;
    logic        hl;
    logic [7:0]  hdi;
    logic [15:0] hwc;
    logic        start_acc;
    logic        line_first;
    logic        line_inc;
    logic        gsp_cap;
    logic        pl_go;
    logic        fe_done;
    logic        last_line;
    state_t      line_state;

    assign last_line  = (line == lat_lines);
    assign line_state = lat_lsle ? S_LS : S_LP;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d    = state;
        hv         = 1'b0;
        hl         = 1'b0;
        hdi        = 8'h00;
        hwc        = 16'h0000;
        gsp_ack    = 1'b0;
        start_acc  = 1'b0;
        line_first = 1'b0;
        line_inc   = 1'b0;
        gsp_cap    = 1'b0;
        pl_go      = 1'b0;
        fe_done    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    start_acc = 1'b1;
                    state_d   = S_FS;
                end
            end
            S_FS: begin
                hv  = 1'b1;
                hdi = {lat_vc, 6'h00};
                hwc = frame_num;
                if (hdr.hdr_ready) begin
                    if (lat_lines == '0) begin
                        state_d = S_FE;
                    end else begin
                        line_first = 1'b1;
                        state_d    = line_state;
                    end
                end
            end
            S_LS: begin
                hv  = 1'b1;
                hdi = {lat_vc, 6'h02};
                hwc = 16'(line);
                if (hdr.hdr_ready) state_d = S_LP;
            end
            S_LP: begin
                hv  = 1'b1;
                hl  = 1'b1;
                hdi = {lat_vc, lat_dt};
                hwc = 16'(lat_wc);
                if (hdr.hdr_ready) begin
                    if (lat_wc == '0) begin
                        state_d = lat_lsle ? S_LE : S_GAP;
                    end else begin
                        pl_go   = 1'b1;
                        state_d = S_PL;
                    end
                end
            end
            S_PL: begin
                if (pl_done) state_d = lat_lsle ? S_LE : S_GAP;
            end
            S_LE: begin
                hv  = 1'b1;
                hdi = {lat_vc, 6'h03};
                hwc = 16'(line);
                if (hdr.hdr_ready) state_d = S_GAP;
            end
            S_GAP: begin
                if (gsp_req) begin
                    gsp_cap = 1'b1;
                    state_d = S_GSP;
                end else if (last_line) begin
                    state_d = S_FE;
                end else begin
                    line_inc = 1'b1;
                    state_d  = line_state;
                end
            end
            S_GSP: begin
                hv  = 1'b1;
                hdi = {lat_vc, gsp_dt_q};
                hwc = gsp_data_q;
                if (hdr.hdr_ready) begin
                    gsp_ack = 1'b1;
                    if (last_line) begin
                        state_d = S_FE;
                    end else begin
                        line_inc = 1'b1;
                        state_d  = line_state;
                    end
                end
            end
            S_FE: begin
                hv  = 1'b1;
                hdi = {lat_vc, 6'h01};
                hwc = frame_num;
                if (hdr.hdr_ready) begin
                    fe_done = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // frame number skips 0 so a receiver can tell "no frame counting"
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lat_vc     <= '0;
            lat_dt     <= '0;
            lat_lines  <= '0;
            lat_wc     <= '0;
            lat_lsle   <= 1'b0;
            frame_num  <= '0;
            line       <= '0;
            gsp_dt_q   <= '0;
            gsp_data_q <= '0;
            pl_start   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            pl_start   <= pl_go;
            frame_done <= fe_done;
            if (start_acc) begin
                lat_vc    <= cfg_vc;
                lat_dt    <= cfg_dt;
                lat_lines <= cfg_lines;
                lat_wc    <= cfg_wc;
                lat_lsle  <= cfg_lsle_en;
                frame_num <= (frame_num == 16'hFFFF) ? 16'h0001
                                                     : frame_num + 16'h0001;
            end
            if (line_first) begin
                line <= LINES_W'(1);
            end else if (line_inc) begin
                line <= line + LINES_W'(1);
            end
            if (gsp_cap) begin
                gsp_dt_q   <= gsp_dt;
                gsp_data_q <= gsp_data;
            end
        end
    end

    assign busy          = (state != S_IDLE);
    assign hdr.hdr_valid = hv;
    assign hdr.hdr_long  = hl;
    assign hdr.hdr_di    = hdi;
    assign hdr.hdr_wc    = hwc;

endmodule

// File: tb/tb_mipi_csi2_frame_sched.sv
// Bench for mipi_csi2_frame_sched: randomized frames against a
// packet-list reference model.
module tb_mipi_csi2_frame_sched;

    typedef struct packed {
        logic [7:0]  di;
        logic [15:0] wc;
        logic        lng;
    } hdr_t;

    logic        clk;
    logic        resetn;
    logic [1:0]  cfg_vc;
    logic [5:0]  cfg_dt;
    logic [11:0] cfg_lines;
    logic [15:0] cfg_wc;
    logic        cfg_lsle_en;
    logic        start;
    logic        busy;
    logic        frame_done;
    logic        gsp_req;
    logic [5:0]  gsp_dt;
    logic [15:0] gsp_data;
    logic        gsp_ack;
    logic        pl_start;
    logic        pl_done;

    mipi_csi2_frame_sched_if hdr_if();

    mipi_csi2_frame_sched #(.LINES_W(12), .WC_W(16)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .cfg_vc     (cfg_vc),
        .cfg_dt     (cfg_dt),
        .cfg_lines  (cfg_lines),
        .cfg_wc     (cfg_wc),
        .cfg_lsle_en(cfg_lsle_en),
        .start      (start),
        .busy       (busy),
        .frame_done (frame_done),
        .gsp_req    (gsp_req),
        .gsp_dt     (gsp_dt),
        .gsp_data   (gsp_data),
        .gsp_ack    (gsp_ack),
        .hdr        (hdr_if.master),
        .pl_start   (pl_start),
        .pl_done    (pl_done)
    );

    int   checks;
    int   errors;
    hdr_t obs_q[$];
    int   pl_cnt;
    int   ack_cnt;
    int   fd_cnt;
    bit   rnd_rdy;
    bit   pl_fix;
    int   pl_max;
    logic [15:0] exp_frame;
    bit   prev_stall;
    hdr_t prev_hdr;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        hdr_if.hdr_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            hdr_if.hdr_ready = rnd_rdy ? (($urandom % 3) != 0) : 1'b1;
        end
    end

    initial begin
        int d;
        pl_done = 1'b0;
        forever begin
            @(negedge clk);
            if (pl_start) begin
                d = pl_fix ? pl_max : int'($urandom_range(pl_max, 0));
                repeat (d) @(negedge clk);
                pl_done = 1'b1;
                @(negedge clk);
                pl_done = 1'b0;
            end
        end
    end

    // handshakes are recorded the half cycle before the edge that takes them
    always @(negedge clk) begin
        hdr_t cur;
        cur = '{di: hdr_if.hdr_di, wc: hdr_if.hdr_wc, lng: hdr_if.hdr_long};
        if (!resetn) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (hdr_if.hdr_valid !== 1'b1 || cur !== prev_hdr) begin
                    errors++;
                    $display("FAIL stall_stable got v=%b %h exp v=1 %h",
                             hdr_if.hdr_valid, cur, prev_hdr);
                end
            end
            if (hdr_if.hdr_valid && hdr_if.hdr_ready) obs_q.push_back(cur);
            if (pl_start) begin
                pl_cnt++;
                checks++;
                if (obs_q.size() == 0 || obs_q[$].lng !== 1'b1) begin
                    errors++;
                    $display("FAIL pl_start_order got no long hdr before pl_start exp long hdr");
                end
            end
            if (gsp_ack) begin
                ack_cnt++;
                checks++;
                if (!(hdr_if.hdr_valid && hdr_if.hdr_ready)
                    || hdr_if.hdr_di[5:0] !== gsp_dt) begin
                    errors++;
                    $display("FAIL gsp_ack_hs got v=%b r=%b dt=%h exp 1 1 %h",
                             hdr_if.hdr_valid, hdr_if.hdr_ready,
                             hdr_if.hdr_di[5:0], gsp_dt);
                end
            end
            if (frame_done) fd_cnt++;
            prev_stall = hdr_if.hdr_valid && !hdr_if.hdr_ready;
            prev_hdr   = cur;
        end
    end

    function automatic logic [15:0] next_frame(input logic [15:0] f);
        return (f == 16'hFFFF) ? 16'h0001 : f + 16'h0001;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        resetn    = 1'b1;
        exp_frame = 16'h0000;
    endtask

    task automatic run_frame(input logic [1:0] vc, input logic [5:0] dt,
                             input int lines, input int wc, input bit lsle,
                             input bit gsp, input logic [5:0] gdt,
                             input logic [15:0] gdata, input bit noise,
                             input string name);
        hdr_t exp_q[$];
        int   cyc;
        int   exp_pl;
        int   exp_ack;
        exp_frame = next_frame(exp_frame);
        exp_q.push_back('{di: {vc, 6'h00}, wc: exp_frame, lng: 1'b0});
        for (int l = 1; l <= lines; l++) begin
            if (lsle) exp_q.push_back('{di: {vc, 6'h02}, wc: 16'(l), lng: 1'b0});
            exp_q.push_back('{di: {vc, dt}, wc: 16'(wc), lng: 1'b1});
            if (lsle) exp_q.push_back('{di: {vc, 6'h03}, wc: 16'(l), lng: 1'b0});
            if (gsp && l == 1) exp_q.push_back('{di: {vc, gdt}, wc: gdata, lng: 1'b0});
        end
        exp_q.push_back('{di: {vc, 6'h01}, wc: exp_frame, lng: 1'b0});
        exp_pl  = (wc != 0) ? lines : 0;
        exp_ack = (gsp && lines > 0) ? 1 : 0;

        @(posedge clk);
        #1;
        obs_q.delete();
        pl_cnt      = 0;
        ack_cnt     = 0;
        fd_cnt      = 0;
        cfg_vc      = vc;
        cfg_dt      = dt;
        cfg_lines   = 12'(lines);
        cfg_wc      = 16'(wc);
        cfg_lsle_en = lsle;
        gsp_req     = gsp;
        gsp_dt      = gdt;
        gsp_data    = gdata;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_rise got %b exp 1", name, busy);
        end
        cfg_vc      = 2'($urandom);
        cfg_dt      = 6'($urandom);
        cfg_lines   = 12'($urandom_range(9, 0));
        cfg_wc      = 16'($urandom);
        cfg_lsle_en = 1'($urandom);
        cyc = 0;
        while (!frame_done && cyc < 3000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (ack_cnt > 0) gsp_req = 1'b0;
            if (!frame_done) start = noise ? 1'($urandom) : 1'b0;
        end
        start   = 1'b0;
        gsp_req = 1'b0;
        checks++;
        if (cyc >= 3000) begin
            errors++;
            $display("FAIL %s timeout got no frame_done exp frame_done", name);
            do_reset();
            return;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_fall got %b exp 0", name, busy);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s hdr_count got %0d exp %0d", name,
                     obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL %s hdr[%0d] got di=%h wc=%h long=%b exp di=%h wc=%h long=%b",
                         name, i, obs_q[i].di, obs_q[i].wc, obs_q[i].lng,
                         exp_q[i].di, exp_q[i].wc, exp_q[i].lng);
            end
        end
        checks++;
        if (pl_cnt != exp_pl) begin
            errors++;
            $display("FAIL %s pl_start_count got %0d exp %0d", name, pl_cnt, exp_pl);
        end
        checks++;
        if (ack_cnt != exp_ack) begin
            errors++;
            $display("FAIL %s gsp_ack_count got %0d exp %0d", name, ack_cnt, exp_ack);
        end
        checks++;
        if (fd_cnt != 1) begin
            errors++;
            $display("FAIL %s frame_done_count got %0d exp 1", name, fd_cnt);
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({busy, frame_done, gsp_ack, hdr_if.hdr_valid, hdr_if.hdr_long,
             pl_start, hdr_if.hdr_di, hdr_if.hdr_wc} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got b=%b fd=%b a=%b v=%b l=%b p=%b di=%h wc=%h exp all 0",
                     busy, frame_done, gsp_ack, hdr_if.hdr_valid,
                     hdr_if.hdr_long, pl_start, hdr_if.hdr_di, hdr_if.hdr_wc);
        end
    endtask

    task automatic test_basic();
        rnd_rdy = 1'b0;
        run_frame(2'd1, 6'h2A, 2, 4, 1'b1, 1'b0, 6'h08, 16'h0, 1'b0, "basic");
    endtask

    task automatic test_no_lsle();
        run_frame(2'd1, 6'h2A, 3, 4, 1'b0, 1'b0, 6'h08, 16'h0, 1'b0, "no_lsle");
    endtask

    task automatic test_gsp();
        gsp_req  = 1'b1;
        gsp_dt   = 6'h08;
        gsp_data = 16'hBEEF;
        ack_cnt  = 0;
        repeat (6) @(negedge clk);
        checks++;
        if (ack_cnt != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL gsp_idle got ack=%0d busy=%b exp ack=0 busy=0", ack_cnt, busy);
        end
        run_frame(2'd1, 6'h2A, 2, 4, 1'b1, 1'b1, 6'h08, 16'hBEEF, 1'b0, "gsp");
    endtask

    task automatic test_stall_random();
        rnd_rdy = 1'b1;
        pl_max  = 20;
        run_frame(2'd1, 6'h2A, 2, 4, 1'b1, 1'b0, 6'h08, 16'h0, 1'b1, "stall");
        for (int k = 0; k < 8; k++) begin
            logic [5:0] dts[3];
            dts[0] = 6'h2A;
            dts[1] = 6'h2B;
            dts[2] = 6'h1E;
            run_frame(2'($urandom), dts[$urandom % 3],
                      int'($urandom_range(4, 1)),
                      (($urandom % 4) == 0) ? 0 : int'($urandom_range(8, 1)),
                      1'($urandom), 1'($urandom),
                      6'h08 + 6'($urandom % 8), 16'($urandom), 1'b1, "random");
        end
        rnd_rdy = 1'b0;
    endtask

    task automatic test_edges();
        run_frame(2'd2, 6'h2A, 0, 4, 1'b1, 1'b0, 6'h08, 16'h0, 1'b0, "lines0");
        run_frame(2'd0, 6'h2B, 2, 0, 1'b1, 1'b0, 6'h08, 16'h0, 1'b0, "wc0");
    endtask

    task automatic test_wrap();
        @(negedge clk);
        force dut.frame_num = 16'hFFFF;
        @(negedge clk);
        release dut.frame_num;
        exp_frame = 16'hFFFF;
        run_frame(2'd1, 6'h2A, 1, 2, 1'b1, 1'b0, 6'h08, 16'h0, 1'b0, "wrap");
    endtask

    task automatic test_reset_mid();
        int cyc;
        pl_fix = 1'b1;
        pl_max = 20;
        @(posedge clk);
        #1;
        pl_cnt      = 0;
        cfg_vc      = 2'd1;
        cfg_dt      = 6'h2A;
        cfg_lines   = 12'd3;
        cfg_wc      = 16'd4;
        cfg_lsle_en = 1'b1;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 0;
        while (pl_cnt == 0 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (pl_cnt == 0) begin
            errors++;
            $display("FAIL rst_mid_pl got no pl_start exp pl_start");
        end
        @(negedge clk);
        resetn = 1'b0;
        #1;
        test_reset();
        repeat (2) @(negedge clk);
        resetn    = 1'b1;
        exp_frame = 16'h0000;
        pl_fix    = 1'b0;
        repeat (25) @(negedge clk);
        run_frame(2'd1, 6'h2A, 1, 4, 1'b1, 1'b0, 6'h08, 16'h0, 1'b0, "after_rst");
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rnd_rdy     = 1'b0;
        pl_fix      = 1'b0;
        pl_max      = 3;
        prev_stall  = 1'b0;
        exp_frame   = 16'h0000;
        resetn      = 1'b0;
        start       = 1'b0;
        cfg_vc      = '0;
        cfg_dt      = '0;
        cfg_lines   = '0;
        cfg_wc      = '0;
        cfg_lsle_en = 1'b0;
        gsp_req     = 1'b0;
        gsp_dt      = '0;
        gsp_data    = '0;
        repeat (3) @(negedge clk);
        test_reset();
        resetn = 1'b1;
        @(negedge clk);
        test_basic();
        test_no_lsle();
        test_gsp();
        test_stall_random();
        test_edges();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
